// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the hazard sequencer and the 5-stage core datapath.
// Exposes hazard inputs, stall/flush controls, halt handshake, perf counters and FSM state.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_MemRead;
  logic             ex_redirect;
  logic             imem_valid;
  // dmem handshake: MEM presents an access with mem_req held high; the access completes
  // in the cycle mem_ack is high; every mem_req cycle without mem_ack freezes the pipe.
  logic             mem_req;
  logic             mem_ack;
  logic             halt_req;

  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             mem_wb_flush;
  logic             halt_ack;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       dbg_state;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_MemRead, ex_redirect,
           imem_valid, mem_req, mem_ack, halt_req,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
           mem_wb_flush, halt_ack, mem_timeout, stall_cnt, flush_cnt, dbg_state
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_MemRead, ex_redirect,
           imem_valid, mem_req, mem_ack, halt_req,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
           mem_wb_flush, halt_ack, mem_timeout, stall_cnt, flush_cnt, dbg_state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32 core: load-use, redirects, memory
// wait states and a halt/drain handshake, with saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.slave  hz
);
  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [1:0]       state_q, state_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic             halt_ack_q, halt_ack_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic freeze, load_use, redirect_taken;
  logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c, id_ex_flush_c;
  logic ex_mem_stall_c, mem_wb_flush_c;

  assign freeze   = hz.mem_req & ~hz.mem_ack;
  assign load_use = hz.ex_MemRead & (hz.ex_rd != 5'd0) &
                    ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                     (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));

  always_comb begin
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_stall_c = 1'b0;
    mem_wb_flush_c = 1'b0;
    redirect_taken = 1'b0;
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;

    // A dmem wait holds every stage; EX is held so a pending redirect survives it.
    if (freeze) begin
      pc_stall_c     = 1'b1;
      if_id_stall_c  = 1'b1;
      id_ex_stall_c  = 1'b1;
      ex_mem_stall_c = 1'b1;
      mem_wb_flush_c = 1'b1;
    end else begin
      case (state_q)
        S_RUN: begin
          if (hz.ex_redirect) begin
            if_id_flush_c  = 1'b1;
            id_ex_flush_c  = 1'b1;
            redirect_taken = 1'b1;
          end else if (load_use) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end else if (!hz.imem_valid) begin
            pc_stall_c    = 1'b1;
            if_id_flush_c = 1'b1;
          end
          if (hz.halt_req) begin
            state_d     = S_DRAIN;
            drain_cnt_d = '0;
          end
        end
        S_DRAIN: begin
          if (hz.ex_redirect) begin
            if_id_flush_c  = 1'b1;
            id_ex_flush_c  = 1'b1;
            redirect_taken = 1'b1;
          end else if (load_use) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end else begin
            pc_stall_c    = 1'b1;
            if_id_flush_c = 1'b1;
          end
          // Once started, the drain completes regardless of halt_req.
          if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) begin
            state_d     = S_HALTED;
            drain_cnt_d = '0;
          end else begin
            drain_cnt_d = drain_cnt_q + DW'(1);
          end
        end
        S_HALTED: begin
          pc_stall_c    = 1'b1;
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
          if (!hz.halt_req) state_d = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end

    if (!freeze)                            wait_cnt_d = '0;
    else if (wait_cnt_q == WW'(TIMEOUT))    wait_cnt_d = wait_cnt_q;
    else                                    wait_cnt_d = wait_cnt_q + WW'(1);
    mem_timeout_d = mem_timeout_q | (wait_cnt_d == WW'(TIMEOUT));
    halt_ack_d    = (state_d == S_HALTED);

    stall_cnt_d = stall_cnt_q;
    if (pc_stall_c && (state_q != S_HALTED) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (redirect_taken && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RUN;
      drain_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      halt_ack_q    <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      halt_ack_q    <= halt_ack_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  // Combinational controls are forced quiet while reset is asserted.
  assign hz.pc_stall     = rst_n & pc_stall_c;
  assign hz.if_id_stall  = rst_n & if_id_stall_c;
  assign hz.if_id_flush  = rst_n & if_id_flush_c;
  assign hz.id_ex_stall  = rst_n & id_ex_stall_c;
  assign hz.id_ex_flush  = rst_n & id_ex_flush_c;
  assign hz.ex_mem_stall = rst_n & ex_mem_stall_c;
  assign hz.mem_wb_flush = rst_n & mem_wb_flush_c;
  assign hz.halt_ack     = halt_ack_q;
  assign hz.mem_timeout  = mem_timeout_q;
  assign hz.stall_cnt    = stall_cnt_q;
  assign hz.flush_cnt    = flush_cnt_q;
  assign hz.dbg_state    = state_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl: drivers push expected per-cycle
// control vectors; a monitor pops and compares them on the falling edge.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int W     = 7 + 1 + 1 + 2 + 2 * CNT_W;

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_LU    = 7'b1100100;
  localparam logic [6:0] C_RED   = 7'b0010100;
  localparam logic [6:0] C_IMISS = 7'b1010000;
  localparam logic [6:0] C_FRZ   = 7'b1101011;
  localparam logic [6:0] C_DRAIN = 7'b1010000;
  localparam logic [6:0] C_HALT  = 7'b1010100;

  logic clk;
  logic rst_n;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(4), .TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           total = 0;
  int           bad   = 0;
  logic [CNT_W-1:0] exp_stall = '0;
  logic [CNT_W-1:0] exp_flush = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        logic [W-1:0] e;
        logic [W-1:0] g;
        string        n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        g = {hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.id_ex_stall, hz.id_ex_flush,
             hz.ex_mem_stall, hz.mem_wb_flush, hz.halt_ack, hz.mem_timeout, hz.dbg_state,
             hz.stall_cnt, hz.flush_cnt};
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL %s: got ctrl=%b ack=%b tmo=%b st=%0d stall=%0d flush=%0d, want ctrl=%b ack=%b tmo=%b st=%0d stall=%0d flush=%0d",
                   n, g[W-1 -: 7], g[W-8], g[W-9], g[W-10 -: 2], g[2*CNT_W-1 -: CNT_W], g[CNT_W-1:0],
                   e[W-1 -: 7], e[W-8], e[W-9], e[W-10 -: 2], e[2*CNT_W-1 -: CNT_W], e[CNT_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic in_idle();
    hz.id_rs1      = 5'd0;
    hz.id_rs2      = 5'd0;
    hz.id_uses_rs1 = 1'b0;
    hz.id_uses_rs2 = 1'b0;
    hz.ex_rd       = 5'd0;
    hz.ex_MemRead  = 1'b0;
    hz.ex_redirect = 1'b0;
    hz.imem_valid  = 1'b1;
    hz.mem_req     = 1'b0;
    hz.mem_ack     = 1'b0;
    hz.halt_req    = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2);
    hz.ex_MemRead  = 1'b1;
    hz.ex_rd       = rd;
    hz.id_rs1      = rs1;
    hz.id_rs2      = rs2;
    hz.id_uses_rs1 = u1;
    hz.id_uses_rs2 = u2;
  endtask

  // Push this cycle's expectation (counters as seen before this cycle's update),
  // advance the expected counters, then move to just after the next rising edge.
  task automatic cyc(input string n, input logic [6:0] ctrl, input logic ack,
                     input logic tmo, input logic [1:0] st);
    exp_q.push_back({ctrl, ack, tmo, st, exp_stall, exp_flush});
    name_q.push_back(n);
    if (ctrl[6] && (st != S_HALTED) && (exp_stall != '1)) exp_stall = exp_stall + 1'b1;
    if (ctrl[2] && !ctrl[6] && (exp_flush != '1))          exp_flush = exp_flush + 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    in_idle();
    @(posedge clk);
    #1;
    set_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    cyc("reset_gates_outputs", C_NONE, 1'b0, 1'b0, S_RUN);
    rst_n = 1'b1;
    in_idle();
    cyc("idle_after_reset", C_NONE, 1'b0, 1'b0, S_RUN);

    set_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    cyc("load_use_rs1", C_LU, 1'b0, 1'b0, S_RUN);
    in_idle();
    cyc("idle_stall_cnt_1", C_NONE, 1'b0, 1'b0, S_RUN);
    set_lu(5'd7, 5'd0, 5'd7, 1'b0, 1'b0);
    cyc("rs2_match_unused", C_NONE, 1'b0, 1'b0, S_RUN);
    set_lu(5'd7, 5'd0, 5'd7, 1'b0, 1'b1);
    cyc("load_use_rs2", C_LU, 1'b0, 1'b0, S_RUN);
    set_lu(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    cyc("x0_no_hazard", C_NONE, 1'b0, 1'b0, S_RUN);
    set_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    hz.ex_redirect = 1'b1;
    cyc("redirect_over_lu", C_RED, 1'b0, 1'b0, S_RUN);
    in_idle();
    hz.imem_valid = 1'b0;
    cyc("imem_miss", C_IMISS, 1'b0, 1'b0, S_RUN);
    hz.ex_redirect = 1'b1;
    cyc("redirect_over_imiss", C_RED, 1'b0, 1'b0, S_RUN);

    // Three-cycle dmem wait with a held redirect behind it.
    in_idle();
    set_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    hz.ex_redirect = 1'b1;
    hz.mem_req     = 1'b1;
    for (int i = 0; i < 3; i++) cyc("freeze_wait", C_FRZ, 1'b0, 1'b0, S_RUN);
    hz.mem_ack = 1'b1;
    cyc("ack_cycle_redirect", C_RED, 1'b0, 1'b0, S_RUN);
    in_idle();
    cyc("after_freeze", C_NONE, 1'b0, 1'b0, S_RUN);

    // Halt with a mid-drain freeze, a redirect and a load-use inside the drain.
    hz.halt_req = 1'b1;
    cyc("halt_req_run", C_NONE, 1'b0, 1'b0, S_RUN);
    cyc("drain_1", C_DRAIN, 1'b0, 1'b0, S_DRAIN);
    cyc("drain_2", C_DRAIN, 1'b0, 1'b0, S_DRAIN);
    hz.mem_req = 1'b1;
    cyc("drain_freeze", C_FRZ, 1'b0, 1'b0, S_DRAIN);
    hz.mem_req     = 1'b0;
    hz.ex_redirect = 1'b1;
    cyc("drain_3_redirect", C_RED, 1'b0, 1'b0, S_DRAIN);
    hz.ex_redirect = 1'b0;
    set_lu(5'd9, 5'd9, 5'd0, 1'b1, 1'b0);
    cyc("drain_4_load_use", C_LU, 1'b0, 1'b0, S_DRAIN);
    in_idle();
    hz.halt_req = 1'b1;
    cyc("halted_1", C_HALT, 1'b1, 1'b0, S_HALTED);
    hz.mem_req = 1'b1;
    cyc("halted_freeze", C_FRZ, 1'b1, 1'b0, S_HALTED);
    hz.mem_req  = 1'b0;
    hz.halt_req = 1'b0;
    cyc("halted_release", C_HALT, 1'b1, 1'b0, S_HALTED);
    cyc("resume_run", C_NONE, 1'b0, 1'b0, S_RUN);

    // Timeout: six wait cycles, sticky flag from the end of the fourth.
    hz.mem_req = 1'b1;
    for (int i = 0; i < 4; i++) cyc("wait_pre_timeout", C_FRZ, 1'b0, 1'b0, S_RUN);
    for (int i = 0; i < 2; i++) cyc("wait_timed_out", C_FRZ, 1'b0, 1'b1, S_RUN);
    hz.mem_ack = 1'b1;
    cyc("timeout_ack", C_NONE, 1'b0, 1'b1, S_RUN);
    in_idle();
    cyc("timeout_sticky", C_NONE, 1'b0, 1'b1, S_RUN);

    // Counter saturation.
    hz.imem_valid = 1'b0;
    for (int i = 0; i < 5; i++) cyc("stall_sat_run", C_IMISS, 1'b0, 1'b1, S_RUN);
    in_idle();
    hz.ex_redirect = 1'b1;
    for (int i = 0; i < 16; i++) cyc("flush_sat_run", C_RED, 1'b0, 1'b1, S_RUN);
    in_idle();
    cyc("counters_saturated", C_NONE, 1'b0, 1'b1, S_RUN);

    // Async reset in the middle of a dmem wait inside DRAIN.
    hz.halt_req = 1'b1;
    cyc("halt_req_2", C_NONE, 1'b0, 1'b1, S_RUN);
    cyc("drain2_1", C_DRAIN, 1'b0, 1'b1, S_DRAIN);
    hz.mem_req     = 1'b1;
    hz.ex_redirect = 1'b1;
    for (int i = 0; i < 4; i++) cyc("drain2_freeze", C_FRZ, 1'b0, 1'b1, S_DRAIN);
    rst_n = 1'b0;
    exp_stall = '0;
    exp_flush = '0;
    cyc("reset_mid_freeze", C_NONE, 1'b0, 1'b0, S_RUN);
    cyc("reset_held", C_NONE, 1'b0, 1'b0, S_RUN);
    rst_n = 1'b1;
    in_idle();
    cyc("after_reset_run", C_NONE, 1'b0, 1'b0, S_RUN);

    // halt_req dropped mid-drain still completes the drain.
    hz.halt_req = 1'b1;
    cyc("halt_req_3", C_NONE, 1'b0, 1'b0, S_RUN);
    hz.halt_req = 1'b0;
    for (int i = 0; i < 4; i++) cyc("drain3", C_DRAIN, 1'b0, 1'b0, S_DRAIN);
    cyc("halted_3", C_HALT, 1'b1, 1'b0, S_HALTED);
    cyc("resume_run_3", C_NONE, 1'b0, 1'b0, S_RUN);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_queue: got %0d pending entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
